decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV32I instruction-decode pipeline stage. It sits between fetch and execute in the core.
//  Decodes one 32-bit instruction per accepted beat into register fields, a one-hot class vector and
//  system sub-flags. Uses valid/ready handshakes on both sides with a 2-entry skid buffer.
//  Adds optional M and Zicsr decode, synchronous flush and a saturating illegal-instruction counter.
// PARAMETERS
//  SUPPORT_M      0   1: decode MUL/DIV (opcode 0110011, funct7 0000001) as class MULDIV; 0: illegal
//  SUPPORT_ZICSR  1   1: CSR* instructions legal; 0: any SYSTEM with funct3!=000 is illegal
//  CNT_WIDTH      16  width of illegal_count (>=1)
// PORTS
//  clk             in   1   core clock
//  rst             in   1   asynchronous reset, active-high
//  flush           in   1   synchronous pipeline flush (branch/trap redirect)
//  in_valid        in   1   fetch has an instruction
//  in_ready        out  1   stage can accept (registered)
//  in_instruction  in   32  raw instruction
//  in_pc           in   32  PC of in_instruction
//  out_valid       out  1   head entry valid
//  out_ready       in   1   execute consumes head
//  out_pc          out  32  PC of head
//  out_instruction out  32  raw head instruction (immediates are extracted by execute)
//  out_rd/out_rs1/out_rs2  out 5 each   bits [11:7]/[19:15]/[24:20]
//  out_funct3      out  3   bits [14:12]
//  out_funct7      out  7   bits [31:25]
//  out_class       out  12  one-hot {SYS,CSR,FENCE,MULDIV,ALU,ALUIMM,STORE,LOAD,BRANCH,JALR,JAL,AUIPC/LUI...}, see pkg
//  out_sys         out  7   {csr_imm,csr_rw,csr_rs,csr_rc,ecall,ebreak,mret}
//  out_illegal     out  1   head instruction is illegal (out_class all-zero)
//  illegal_count   out  CNT_WIDTH  saturating count of illegal instructions handed to execute
// BEHAVIOUR
//  Reset (async): both entries empty, out_valid=0, in_ready=1, illegal_count=0, all out_* fields 0.
//  Decode happens combinationally on the input; results are stored with the entry. Latency: an accept
//   at edge N is presented with out_valid=1 after edge N. No combinational in->out path.
//  Accept = in_valid&in_ready; consume = out_valid&out_ready. in_ready depends only on state.
//  FSM occupancy: EMPTY(out_valid=0,in_ready=1), ONE(out_valid=1,in_ready=1), FULL(out_valid=1,in_ready=0).
//   EMPTY: accept->ONE.  ONE: accept&!consume->FULL; consume&!accept->EMPTY; both->ONE (new head).
//   FULL: consume->ONE, skid entry becomes head. Order is strictly FIFO.
//  flush: at next edge both entries are cleared and state goes to EMPTY. It overrides a simultaneous
//   accept (the input is dropped) and a simultaneous consume. illegal_count still counts a consume in that cycle.
//  When out_valid=0 every out_* field is driven 0 (decoded bubble).
//  Classes: LUI 0110111; AUIPC 0010111; JAL 1101111; JALR 1100111&f3=000; BRANCH 1100011&f3!={010,011};
//   LOAD 0000011&f3 in{000,001,010,100,101}; STORE 0100011&f3 in{000,001,010};
//   ALUIMM 0010011 (f3=001: f7=0000000; f3=101: f7 in{0000000,0100000});
//   ALU 0110011&(f7=0000000 | f7=0100000&f3 in{000,101}); MULDIV per SUPPORT_M; FENCE 0001111&f3=000;
//   CSR 1110011&f3!=000&f3!=100 (per SUPPORT_ZICSR); SYS 1110011&[31:7] matches ECALL/EBREAK/MRET.
//   csr_imm=f3[2]; rw/rs/rc = f3[1:0] 01/10/11; ecall/ebreak/mret only with class SYS.
//  Illegal: bits[1:0]!=11 (compressed), or no class matched (out_class=0). Unsupported SYSTEM (e.g. WFI) is illegal.
//  illegal_count: +1 per consume of an illegal head; saturates at 2^CNT_WIDTH-1 and never wraps.
// STRUCTURE
//  Package decode_pkg: opcode localparams, CLASS_* bit indices, CLASS_W=12, SYS_* bit indices.
//  Sub-module rv32_decode_comb: pure combinational decoder (instruction -> fields, class, sys, illegal).
//  decode_stage contains the 2-entry skid buffer, the FSM, flush handling and the counter.
// TESTING
//  1 Reset mid-stream with state FULL -> out_valid=0, in_ready=1, illegal_count=0 immediately (async).
//  2 ADDI x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, class ALUIMM, rd=1, rs1=0, illegal=0.
//  3 out_ready=0; push 0x00500093,0x00100113,0x00200193 -> first two accepted, in_ready=0, third held;
//    release -> outputs appear in push order, one per cycle.
//  4 MUL 0x02208033: SUPPORT_M=0 -> out_illegal=1, count 0->1; SUPPORT_M=1 -> class MULDIV, count stays 0.
//  5 0x00000073->ecall, 0x00100073->ebreak, 0x30200073->mret, 0x10500073 (WFI)->illegal,
//    0x00004501 (compressed)->illegal, 0x34011073 (csrrw)->CSR+csr_rw.
//  6 State FULL, flush=1 with in_valid=1 and out_ready=1 -> next cycle EMPTY, input not captured.
//    Separately, CNT_WIDTH=2 and 5 illegal consumes -> illegal_count=3.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, class/sys bit positions, entry structs.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSN_MRET   = 32'h3020_0073;

  // One-hot class vector; LUI and AUIPC share the upper-immediate bit.
  localparam int CLASS_W      = 12;
  localparam int CLASS_UPPER  = 0;
  localparam int CLASS_JAL    = 1;
  localparam int CLASS_JALR   = 2;
  localparam int CLASS_BRANCH = 3;
  localparam int CLASS_LOAD   = 4;
  localparam int CLASS_STORE  = 5;
  localparam int CLASS_ALUIMM = 6;
  localparam int CLASS_ALU    = 7;
  localparam int CLASS_MULDIV = 8;
  localparam int CLASS_FENCE  = 9;
  localparam int CLASS_CSR    = 10;
  localparam int CLASS_SYS    = 11;

  // System sub-flags, packed as {csr_imm,csr_rw,csr_rs,csr_rc,ecall,ebreak,mret}.
  localparam int SYS_W       = 7;
  localparam int SYS_MRET    = 0;
  localparam int SYS_EBREAK  = 1;
  localparam int SYS_ECALL   = 2;
  localparam int SYS_CSR_RC  = 3;
  localparam int SYS_CSR_RS  = 4;
  localparam int SYS_CSR_RW  = 5;
  localparam int SYS_CSR_IMM = 6;

  typedef struct packed {
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [CLASS_W-1:0] cls;
    logic [SYS_W-1:0]   sys;
    logic               illegal;
  } decoded_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    decoded_t    dec;
  } entry_t;

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage, plus flush and the illegal counter.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready towards fetch, out_valid/out_ready from execute.
// Modports: master = surrounding core (drives in_*, out_ready, flush); slave = decode_stage.
interface decode_if #(parameter int CNT_WIDTH = 16);
  import decode_pkg::*;

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instruction;
  logic [31:0]          in_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_pc;
  logic [31:0]          out_instruction;
  logic [4:0]           out_rd;
  logic [4:0]           out_rs1;
  logic [4:0]           out_rs2;
  logic [2:0]           out_funct3;
  logic [6:0]           out_funct7;
  logic [CLASS_W-1:0]   out_class;
  logic [SYS_W-1:0]     out_sys;
  logic                 out_illegal;
  logic [CNT_WIDTH-1:0] illegal_count;

  modport master (
    output flush, in_valid, in_instruction, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_instruction, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_class, out_sys, out_illegal, illegal_count
  );

  modport slave (
    input  flush, in_valid, in_instruction, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_instruction, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_class, out_sys, out_illegal, illegal_count
  );
endinterface

// File: rtl/rv32_decode_comb.sv
// Pure combinational RV32I(+M, +Zicsr) decoder: instruction -> register fields, class, sys flags, illegal.
// Latency: 0 cycles (combinational).
// Backpressure: none.
// Ports: instruction (32b in), dec (decoded_t out).
module rv32_decode_comb
  import decode_pkg::*;
#(
  parameter int SUPPORT_M     = 0,
  parameter int SUPPORT_ZICSR = 1
) (
  input  logic [31:0] instruction,
  output decoded_t    dec
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [CLASS_W-1:0] cls;
  logic [SYS_W-1:0]   sys;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  // Compressed encodings (bits[1:0] != 11) never match a 7-bit opcode, so they fall out as class 0.
  always_comb begin
    cls = '0;
    sys = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: cls[CLASS_UPPER] = 1'b1;
      OP_JAL:           cls[CLASS_JAL]   = 1'b1;
      OP_JALR:          cls[CLASS_JALR]  = (funct3 == 3'b000);
      OP_BRANCH:        cls[CLASS_BRANCH] = (funct3 != 3'b010) && (funct3 != 3'b011);
      OP_LOAD:          cls[CLASS_LOAD]  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      OP_STORE:         cls[CLASS_STORE] = funct3 inside {3'b000, 3'b001, 3'b010};
      OP_ALUIMM: begin
        // Shift-immediates reuse funct7 as a sub-opcode; everything else is a plain immediate.
        case (funct3)
          3'b001:  cls[CLASS_ALUIMM] = (funct7 == 7'b0000000);
          3'b101:  cls[CLASS_ALUIMM] = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: cls[CLASS_ALUIMM] = 1'b1;
        endcase
      end
      OP_ALU: begin
        cls[CLASS_ALU]    = (funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) && (funct3 inside {3'b000, 3'b101}));
        cls[CLASS_MULDIV] = (SUPPORT_M != 0) && (funct7 == 7'b0000001);
      end
      OP_FENCE:         cls[CLASS_FENCE] = (funct3 == 3'b000);
      OP_SYSTEM: begin
        if (funct3 == 3'b000) begin
          // Only exact ECALL/EBREAK/MRET encodings are accepted; WFI and friends stay illegal.
          sys[SYS_ECALL]  = (instruction == INSN_ECALL);
          sys[SYS_EBREAK] = (instruction == INSN_EBREAK);
          sys[SYS_MRET]   = (instruction == INSN_MRET);
          cls[CLASS_SYS]  = |sys;
        end else if ((funct3 != 3'b100) && (SUPPORT_ZICSR != 0)) begin
          cls[CLASS_CSR]   = 1'b1;
          sys[SYS_CSR_IMM] = funct3[2];
          sys[SYS_CSR_RW]  = (funct3[1:0] == 2'b01);
          sys[SYS_CSR_RS]  = (funct3[1:0] == 2'b10);
          sys[SYS_CSR_RC]  = (funct3[1:0] == 2'b11);
        end
      end
      default: ;
    endcase
  end

  assign dec.rd      = instruction[11:7];
  assign dec.rs1     = instruction[19:15];
  assign dec.rs2     = instruction[24:20];
  assign dec.funct3  = funct3;
  assign dec.funct7  = funct7;
  assign dec.cls     = cls;
  assign dec.sys     = sys;
  assign dec.illegal = ~|cls;

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer, flush and saturating illegal counter.
// Latency: accept at edge N is presented (out_valid=1) after edge N; no combinational in->out path.
// Backpressure: in_ready depends only on occupancy (low when both entries are full).
// Ports: clk, rst (async, active-high), bus (decode_if.slave: fetch side in_*, execute side out_*,
//        flush, illegal_count).
module decode_stage
  import decode_pkg::*;
#(
  parameter int SUPPORT_M     = 0,
  parameter int SUPPORT_ZICSR = 1,
  parameter int CNT_WIDTH     = 16
) (
  input logic     clk,
  input logic     rst,
  decode_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               stateQ, stateD;
  entry_t               headQ, skidQ, inEntry, headOut;
  decoded_t             inDec;
  logic [CNT_WIDTH-1:0] illegalCount;
  logic                 inReady, outValid, accept, consume;
  logic                 loadHead, loadSkid, promoteSkid;

  rv32_decode_comb #(
    .SUPPORT_M     (SUPPORT_M),
    .SUPPORT_ZICSR (SUPPORT_ZICSR)
  ) uDecode (
    .instruction (bus.in_instruction),
    .dec         (inDec)
  );

  assign inEntry = '{pc: bus.in_pc, instr: bus.in_instruction, dec: inDec};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateQ <= EMPTY;
    else     stateQ <= stateD;
  end

  always_comb begin
    stateD      = stateQ;
    loadHead    = 1'b0;
    loadSkid    = 1'b0;
    promoteSkid = 1'b0;
    inReady     = (stateQ != FULL);
    outValid    = (stateQ != EMPTY);
    accept      = bus.in_valid && inReady;
    consume     = outValid && bus.out_ready;
    case (stateQ)
      EMPTY: if (accept) begin
        stateD   = ONE;
        loadHead = 1'b1;
      end
      ONE: begin
        if (accept && !consume) begin
          stateD   = FULL;
          loadSkid = 1'b1;
        end else if (accept && consume) begin
          loadHead = 1'b1;
        end else if (consume) begin
          stateD = EMPTY;
        end
      end
      FULL: if (consume) begin
        stateD      = ONE;
        promoteSkid = 1'b1;
      end
      default: stateD = EMPTY;
    endcase
    // Flush wins over any accept/consume in the same cycle.
    if (bus.flush) stateD = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headQ <= '0;
      skidQ <= '0;
    end else if (bus.flush) begin
      headQ <= '0;
      skidQ <= '0;
    end else begin
      if (loadHead)    headQ <= inEntry;
      if (promoteSkid) headQ <= skidQ;
      if (loadSkid)    skidQ <= inEntry;
    end
  end

  // Counts illegal heads actually handed to execute, including one consumed alongside a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegalCount <= '0;
    end else if (consume && headQ.dec.illegal && (illegalCount != CNT_MAX)) begin
      illegalCount <= illegalCount + CNT_ONE;
    end
  end

  // Bubbles present an all-zero decoded entry.
  assign headOut = outValid ? headQ : '0;

  assign bus.in_ready        = inReady;
  assign bus.out_valid       = outValid;
  assign bus.out_pc          = headOut.pc;
  assign bus.out_instruction = headOut.instr;
  assign bus.out_rd          = headOut.dec.rd;
  assign bus.out_rs1         = headOut.dec.rs1;
  assign bus.out_rs2         = headOut.dec.rs2;
  assign bus.out_funct3      = headOut.dec.funct3;
  assign bus.out_funct7      = headOut.dec.funct7;
  assign bus.out_class       = headOut.dec.cls;
  assign bus.out_sys         = headOut.dec.sys;
  assign bus.out_illegal     = headOut.dec.illegal;
  assign bus.illegal_count   = illegalCount;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: three instances (base, with M, 2-bit counter) share one stimulus stream.
// Latency: n/a.
// Backpressure: driven directly through out_ready.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, inValid, outReady;
  logic [31:0] inInstr, inPc;
  int          asserts = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  decode_if #(.CNT_WIDTH(16)) busA();
  decode_if #(.CNT_WIDTH(16)) busM();
  decode_if #(.CNT_WIDTH(2))  busS();

  assign busA.flush = flush;  assign busA.in_valid = inValid;  assign busA.in_instruction = inInstr;
  assign busA.in_pc = inPc;   assign busA.out_ready = outReady;
  assign busM.flush = flush;  assign busM.in_valid = inValid;  assign busM.in_instruction = inInstr;
  assign busM.in_pc = inPc;   assign busM.out_ready = outReady;
  assign busS.flush = flush;  assign busS.in_valid = inValid;  assign busS.in_instruction = inInstr;
  assign busS.in_pc = inPc;   assign busS.out_ready = outReady;

  decode_stage #(.SUPPORT_M(0), .SUPPORT_ZICSR(1), .CNT_WIDTH(16)) dutA (.clk(clk), .rst(rst), .bus(busA));
  decode_stage #(.SUPPORT_M(1), .SUPPORT_ZICSR(1), .CNT_WIDTH(16)) dutM (.clk(clk), .rst(rst), .bus(busM));
  decode_stage #(.SUPPORT_M(0), .SUPPORT_ZICSR(1), .CNT_WIDTH(2))  dutS (.clk(clk), .rst(rst), .bus(busS));

  typedef struct packed {
    logic [31:0] instr;
    logic [11:0] cls;    // expected class, base instance
    logic [11:0] clsM;   // expected class, M-enabled instance
    logic [6:0]  sys;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] oh(input int b);
    return 12'(1) << b;
  endfunction

  function automatic logic [6:0] ohs(input int b);
    return 7'(1) << b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int expA, expM, expS;
    logic [11:0] none;
    none = '0;

    vecs.push_back('{32'h0050_0093, oh(CLASS_ALUIMM), oh(CLASS_ALUIMM), 7'h0, 5'd1});  // addi x1,x0,5
    vecs.push_back('{32'h0010_0113, oh(CLASS_ALUIMM), oh(CLASS_ALUIMM), 7'h0, 5'd2});  // addi x2,x0,1
    vecs.push_back('{32'h0220_8033, none, oh(CLASS_MULDIV), 7'h0, 5'd0});             // mul x0,x1,x2
    vecs.push_back('{32'h0000_0073, oh(CLASS_SYS), oh(CLASS_SYS), ohs(SYS_ECALL), 5'd0});
    vecs.push_back('{32'h0010_0073, oh(CLASS_SYS), oh(CLASS_SYS), ohs(SYS_EBREAK), 5'd0});
    vecs.push_back('{32'h3020_0073, oh(CLASS_SYS), oh(CLASS_SYS), ohs(SYS_MRET), 5'd0});
    vecs.push_back('{32'h1050_0073, none, none, 7'h0, 5'd0});                         // wfi
    vecs.push_back('{32'h0000_4501, none, none, 7'h0, 5'd10});                        // compressed
    vecs.push_back('{32'h3401_1073, oh(CLASS_CSR), oh(CLASS_CSR), ohs(SYS_CSR_RW), 5'd0});
    vecs.push_back('{32'h0000_7073, oh(CLASS_CSR), oh(CLASS_CSR), ohs(SYS_CSR_IMM) | ohs(SYS_CSR_RC), 5'd0});
    vecs.push_back('{32'h0020_81b3, oh(CLASS_ALU), oh(CLASS_ALU), 7'h0, 5'd3});        // add
    vecs.push_back('{32'h4020_81b3, oh(CLASS_ALU), oh(CLASS_ALU), 7'h0, 5'd3});        // sub
    vecs.push_back('{32'h4020_91b3, none, none, 7'h0, 5'd3});                         // bad f7 for sll
    vecs.push_back('{32'h1234_52b7, oh(CLASS_UPPER), oh(CLASS_UPPER), 7'h0, 5'd5});    // lui
    vecs.push_back('{32'h0000_0097, oh(CLASS_UPPER), oh(CLASS_UPPER), 7'h0, 5'd1});    // auipc
    vecs.push_back('{32'h0000_0063, oh(CLASS_BRANCH), oh(CLASS_BRANCH), 7'h0, 5'd0});  // beq
    vecs.push_back('{32'h0000_2063, none, none, 7'h0, 5'd0});                         // branch f3=010
    vecs.push_back('{32'h0000_000f, oh(CLASS_FENCE), oh(CLASS_FENCE), 7'h0, 5'd0});
    vecs.push_back('{32'h0000_100f, none, none, 7'h0, 5'd0});                         // fence.i
    vecs.push_back('{32'h0000_a103, oh(CLASS_LOAD), oh(CLASS_LOAD), 7'h0, 5'd2});      // lw
    vecs.push_back('{32'h0000_b103, none, none, 7'h0, 5'd2});                         // ld
    vecs.push_back('{32'h0000_2023, oh(CLASS_STORE), oh(CLASS_STORE), 7'h0, 5'd0});    // sw
    vecs.push_back('{32'h0000_3023, none, none, 7'h0, 5'd0});                         // sd
    vecs.push_back('{32'h0000_00ef, oh(CLASS_JAL), oh(CLASS_JAL), 7'h0, 5'd1});
    vecs.push_back('{32'h0000_80e7, oh(CLASS_JALR), oh(CLASS_JALR), 7'h0, 5'd1});
    vecs.push_back('{32'h0000_90e7, none, none, 7'h0, 5'd1});                         // jalr f3=001
    vecs.push_back('{32'h4000_9093, none, none, 7'h0, 5'd1});                         // slli bad f7
    vecs.push_back('{32'h4000_d093, oh(CLASS_ALUIMM), oh(CLASS_ALUIMM), 7'h0, 5'd1});  // srai

    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0; inInstr = '0; inPc = '0;
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(busA.out_valid), 32'd0);
    check("reset in_ready", 32'(busA.in_ready), 32'd1);
    check("reset count", 32'(busA.illegal_count), 32'd0);
    check("reset class", 32'(busA.out_class), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table: one instruction per cycle with execute always ready.
    expA = 0; expM = 0; expS = 0;
    outReady = 1'b1;
    foreach (vecs[i]) begin
      inValid = 1'b1;
      inInstr = vecs[i].instr;
      inPc    = 32'h1000 + 32'(i * 4);
      step();
      inValid = 1'b0;
      check($sformatf("v%0d valid", i),   32'(busA.out_valid),       32'd1);
      check($sformatf("v%0d instr", i),   busA.out_instruction,      vecs[i].instr);
      check($sformatf("v%0d pc", i),      busA.out_pc,               32'h1000 + 32'(i * 4));
      check($sformatf("v%0d class", i),   32'(busA.out_class),       32'(vecs[i].cls));
      check($sformatf("v%0d classM", i),  32'(busM.out_class),       32'(vecs[i].clsM));
      check($sformatf("v%0d illegal", i), 32'(busA.out_illegal),     32'(vecs[i].cls == 0));
      check($sformatf("v%0d illegalM", i), 32'(busM.out_illegal),    32'(vecs[i].clsM == 0));
      check($sformatf("v%0d sys", i),     32'(busA.out_sys),         32'(vecs[i].sys));
      check($sformatf("v%0d rd", i),      32'(busA.out_rd),          32'(vecs[i].rd));
      check($sformatf("v%0d count", i),   32'(busA.illegal_count),   32'(expA));
      check($sformatf("v%0d countM", i),  32'(busM.illegal_count),   32'(expM));
      check($sformatf("v%0d countS", i),  32'(busS.illegal_count),   32'(expS));
      if (i == 0) begin
        check("addi rs1", 32'(busA.out_rs1), 32'd0);
        check("addi rs2", 32'(busA.out_rs2), 32'd5);
        check("addi funct3", 32'(busA.out_funct3), 32'd0);
        check("addi funct7", 32'(busA.out_funct7), 32'd0);
      end
      // The head is consumed at the next edge.
      if (vecs[i].cls == 0) expA++;
      if (vecs[i].clsM == 0) expM++;
      if (vecs[i].cls == 0 && expS < 3) expS++;
    end
    step();
    check("drain out_valid", 32'(busA.out_valid), 32'd0);
    check("drain bubble instr", busA.out_instruction, 32'd0);
    check("drain count", 32'(busA.illegal_count), 32'(expA));
    check("drain countM", 32'(busM.illegal_count), 32'(expM));
    check("count saturates at 3", 32'(busS.illegal_count), 32'd3);

    // Skid buffer fill, stall and in-order drain.
    outReady = 1'b0;
    inValid = 1'b1; inInstr = 32'h0050_0093;
    step();
    check("fill1 in_ready", 32'(busA.in_ready), 32'd1);
    inInstr = 32'h0010_0113;
    step();
    check("fill2 in_ready", 32'(busA.in_ready), 32'd0);
    check("fill2 head", busA.out_instruction, 32'h0050_0093);
    inInstr = 32'h0020_0193;
    step();
    check("stall in_ready", 32'(busA.in_ready), 32'd0);
    check("stall head", busA.out_instruction, 32'h0050_0093);
    outReady = 1'b1;
    step();
    check("drain1 head", busA.out_instruction, 32'h0010_0113);
    check("drain1 in_ready", 32'(busA.in_ready), 32'd1);
    step();
    inValid = 1'b0;
    check("drain2 head", busA.out_instruction, 32'h0020_0193);
    check("drain2 rd", 32'(busA.out_rd), 32'd3);
    step();
    check("drain3 out_valid", 32'(busA.out_valid), 32'd0);

    // Flush while full with an illegal head being consumed and a new input offered.
    outReady = 1'b0;
    inValid = 1'b1; inInstr = 32'h0000_4501;
    step();
    inInstr = 32'h0000_0013;
    step();
    check("preflush in_ready", 32'(busA.in_ready), 32'd0);
    flush = 1'b1; outReady = 1'b1; inInstr = 32'h0010_0113;
    step();
    flush = 1'b0; inValid = 1'b0;
    check("flush out_valid", 32'(busA.out_valid), 32'd0);
    check("flush in_ready", 32'(busA.in_ready), 32'd1);
    check("flush bubble class", 32'(busA.out_class), 32'd0);
    check("flush counts consume", 32'(busA.illegal_count), 32'(expA + 1));
    check("flush countM", 32'(busM.illegal_count), 32'(expM + 1));
    check("flush countS", 32'(busS.illegal_count), 32'd3);
    step();
    check("flush input dropped", 32'(busA.out_valid), 32'd0);

    // Asynchronous reset while full.
    outReady = 1'b0;
    inValid = 1'b1; inInstr = 32'h0000_4501;
    step();
    step();
    inValid = 1'b0;
    check("prereset in_ready", 32'(busA.in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", 32'(busA.out_valid), 32'd0);
    check("async rst in_ready", 32'(busA.in_ready), 32'd1);
    check("async rst count", 32'(busA.illegal_count), 32'd0);
    check("async rst countS", 32'(busS.illegal_count), 32'd0);
    check("async rst instr", busA.out_instruction, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
